// File: rtl/blit_engine_pkg.sv
// Shared Xosera definitions: blitter register numbers and blitter FSM encodings,
// common to the blitter and the video generator.
package blit_engine_pkg;

    localparam logic [3:0] REG_OP_MODE  = 4'h6;
    localparam logic [3:0] REG_OP_COUNT = 4'h7;
    localparam logic [3:0] REG_ADDR_A   = 4'h9;
    localparam logic [3:0] REG_DATA_A   = 4'hA;
    localparam logic [3:0] REG_INCR_A   = 4'hB;
    localparam logic [3:0] REG_ADDR_B   = 4'hD;
    localparam logic [3:0] REG_INCR_B   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_COPY_RD   = 3'd2,
        ST_COPY_WAIT = 3'd3,
        ST_COPY_WR   = 3'd4
    } blit_state_e;

endpackage

// File: rtl/blit_engine.sv
// VRAM blitter: fills or copies a run of words using the VRAM slots that the
// video generator grants through blit_cycle_i.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | no operation; waits for a nonzero OP_COUNT write
// ST_FILL      | writes DATA_A to addrA on each granted cycle
// ST_COPY_RD   | issues a read of addrB on the next granted cycle
// ST_COPY_WAIT | lets the read strobe complete, then captures the read word
// ST_COPY_WR   | writes the captured word to addrA on the next granted cycle
module blit_engine
    import blit_engine_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              blit_cycle_i,
    input  logic              reg_wr_i,
    input  logic [3:0]        reg_num_i,
    input  logic [15:0]       reg_data_i,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [15:0]       vram_data_o,
    input  logic [15:0]       vram_data_i,
    output logic              busy_o,
    output logic              done_o
);

    blit_state_e state_q, state_d;
    logic busy_q, busy_d, done_q, done_d;
    logic sel_q, sel_d, wr_q, wr_d, wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0] data_q, data_d, hold_q, hold_d, count_q, count_d, data_a_q, data_a_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] incr_a_q, incr_a_d, incr_b_q, incr_b_d;

    logic sh_mode_q;
    logic [15:0] sh_data_a_q;
    logic [ADDR_W-1:0] sh_addr_a_q, sh_incr_a_q, sh_addr_b_q, sh_incr_b_q;

    logic start;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sh_mode_q   <= 1'b0;
            sh_data_a_q <= '0;
            sh_addr_a_q <= '0;
            sh_incr_a_q <= '0;
            sh_addr_b_q <= '0;
            sh_incr_b_q <= '0;
        end else if (reg_wr_i) begin
            unique case (reg_num_i)
                REG_OP_MODE: sh_mode_q   <= reg_data_i[0];
                REG_ADDR_A:  sh_addr_a_q <= reg_data_i[ADDR_W-1:0];
                REG_DATA_A:  sh_data_a_q <= reg_data_i;
                REG_INCR_A:  sh_incr_a_q <= reg_data_i[ADDR_W-1:0];
                REG_ADDR_B:  sh_addr_b_q <= reg_data_i[ADDR_W-1:0];
                REG_INCR_B:  sh_incr_b_q <= reg_data_i[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // done_q excludes the completion cycle, where state is already back in IDLE.
    assign start = reg_wr_i && (reg_num_i == REG_OP_COUNT) && (reg_data_i != 16'd0)
                   && (state_q == ST_IDLE) && !done_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sel_d    = 1'b0;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        hold_d   = hold_q;
        wait_d   = wait_q;
        count_d  = count_q;
        data_a_d = data_a_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        incr_a_d = incr_a_q;
        incr_b_d = incr_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_a_d = sh_addr_a_q;
                    addr_b_d = sh_addr_b_q;
                    incr_a_d = sh_incr_a_q;
                    incr_b_d = sh_incr_b_q;
                    data_a_d = sh_data_a_q;
                    count_d  = reg_data_i;
                    busy_d   = 1'b1;
                    state_d  = sh_mode_q ? ST_COPY_RD : ST_FILL;
                end
            end
            ST_FILL, ST_COPY_WR: begin
                if (blit_cycle_i) begin
                    sel_d    = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = addr_a_q;
                    data_d   = (state_q == ST_FILL) ? data_a_q : hold_q;
                    addr_a_d = addr_a_q + incr_a_q;
                    count_d  = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (state_q == ST_COPY_WR) begin
                        state_d = ST_COPY_RD;
                    end
                end
            end
            ST_COPY_RD: begin
                if (blit_cycle_i) begin
                    sel_d    = 1'b1;
                    wr_d     = 1'b0;
                    addr_d   = addr_b_q;
                    addr_b_d = addr_b_q + incr_b_q;
                    wait_d   = 1'b0;
                    state_d  = ST_COPY_WAIT;
                end
            end
            ST_COPY_WAIT: begin
                // First cycle is the registered read strobe itself; data follows one cycle later.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    hold_d  = vram_data_i;
                    state_d = ST_COPY_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            hold_q   <= '0;
            wait_q   <= 1'b0;
            count_q  <= '0;
            data_a_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            incr_a_q <= '0;
            incr_b_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            hold_q   <= hold_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            data_a_q <= data_a_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            incr_a_q <= incr_a_d;
            incr_b_q <= incr_b_d;
        end
    end

    assign vram_sel_o  = sel_q;
    assign vram_wr_o   = wr_q;
    assign vram_addr_o = addr_q;
    assign vram_data_o = data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_blit_engine.sv
// Scoreboard bench for blit_engine: expected VRAM writes are queued when an
// operation is programmed and popped as the DUT issues write strobes.
module tb_blit_engine;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        blit_cycle_i = 1'b1;
    logic        reg_wr_i = 1'b0;
    logic [3:0]  reg_num_i = '0;
    logic [15:0] reg_data_i = '0;
    logic        vram_sel_o, vram_wr_o, busy_o, done_o;
    logic [15:0] vram_addr_o, vram_data_o;
    logic [15:0] vram_data_i = '0;

    blit_engine #(.ADDR_W(16)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .blit_cycle_i (blit_cycle_i),
        .reg_wr_i     (reg_wr_i),
        .reg_num_i    (reg_num_i),
        .reg_data_i   (reg_data_i),
        .vram_sel_o   (vram_sel_o),
        .vram_wr_o    (vram_wr_o),
        .vram_addr_o  (vram_addr_o),
        .vram_data_o  (vram_data_o),
        .vram_data_i  (vram_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int wr_cyc_q[$];
    logic [15:0] mem [0:65535];
    int cyc = 0, sel_total = 0, wr_total = 0, done_cnt = 0;
    logic bc_edge;
    logic toggle_en = 1'b0;
    logic [1:0] tcnt = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // VRAM model: read data appears one cycle after the read strobe.
    always @(posedge clk)
        if (vram_sel_o && !vram_wr_o) vram_data_i <= mem[vram_addr_o];

    always @(negedge clk) begin
        tcnt = tcnt + 2'd1;
        blit_cycle_i = toggle_en ? tcnt[1] : 1'b1;
    end

    always @(posedge clk) begin
        logic [31:0] e;
        cyc++;
        bc_edge = blit_cycle_i;
        #1;
        if (vram_sel_o) begin
            sel_total++;
            chk("sel_gate", {31'd0, bc_edge}, 32'd1);
            if (vram_wr_o) begin
                wr_total++;
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", {vram_addr_o, vram_data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr", {vram_addr_o, vram_data_o}, e);
                end
                mem[vram_addr_o] = vram_data_o;
            end
        end
        if (done_o) begin
            done_cnt++;
            chk("done_busy", {31'd0, busy_o}, 32'd0);
        end
    end

    task automatic reg_write(input logic [3:0] num, input logic [15:0] data);
        @(negedge clk);
        reg_wr_i = 1'b1; reg_num_i = num; reg_data_i = data;
        @(negedge clk);
        reg_wr_i = 1'b0;
    endtask

    task automatic prog_fill(input logic [15:0] a, input logic [15:0] inc,
                             input logic [15:0] d, input logic [15:0] n);
        reg_write(4'h9, a); reg_write(4'hB, inc); reg_write(4'hA, d);
        reg_write(4'h6, 16'h0000);
        for (int i = 0; i < int'(n); i++) exp_q.push_back({a + inc * 16'(i), d});
        reg_write(4'h7, n);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start_cnt = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != start_cnt) break;
        end
        chk({tag, "_done_seen"}, {31'd0, done_cnt != start_cnt}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int base;
        bit found;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_done", {31'd0, done_o}, 0);
        chk("rst_sel", {31'd0, vram_sel_o}, 0);
        chk("rst_wr", {31'd0, vram_wr_o}, 0);
        chk("rst_addr_data", {vram_addr_o, vram_data_o}, 0);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Fill: 4 writes on consecutive cycles
        wr_cyc_q.delete();
        prog_fill(16'h0100, 16'd1, 16'hABCD, 16'd4);
        chk("fill_busy", {31'd0, busy_o}, 1);
        wait_done("fill", 50);
        chk("fill_count", wr_cyc_q.size(), 4);
        if (wr_cyc_q.size() == 4) chk("fill_span", wr_cyc_q[3] - wr_cyc_q[0], 3);

        // Copy with read-back through the VRAM model
        mem[16'h2000] = 16'h1111; mem[16'h2001] = 16'h2222; mem[16'h2002] = 16'h3333;
        reg_write(4'hD, 16'h2000); reg_write(4'hF, 16'd1);
        reg_write(4'h9, 16'h3000); reg_write(4'hB, 16'd2);
        reg_write(4'h6, 16'h0001);
        exp_q.push_back({16'h3000, 16'h1111});
        exp_q.push_back({16'h3002, 16'h2222});
        exp_q.push_back({16'h3004, 16'h3333});
        reg_write(4'h7, 16'd3);
        wait_done("copy", 100);

        // Throttled fill
        toggle_en = 1'b1;
        base = wr_total;
        prog_fill(16'h0400, 16'd3, 16'h5A5A, 16'd2);
        wait_done("thr", 100);
        chk("thr_count", wr_total - base, 2);
        toggle_en = 1'b0;

        // Address wrap
        prog_fill(16'hFFFF, 16'd1, 16'h7777, 16'd2);
        wait_done("wrap", 50);

        // Zero count ignored
        base = sel_total;
        reg_write(4'h7, 16'd0);
        repeat (5) @(negedge clk);
        chk("zero_busy", {31'd0, busy_o}, 0);
        chk("zero_sel", sel_total - base, 0);

        // OP_COUNT written mid-fill is ignored
        base = wr_total;
        prog_fill(16'h0500, 16'd1, 16'h1234, 16'd3);
        reg_write(4'h7, 16'd5);
        wait_done("midfill", 50);
        chk("midfill_count", wr_total - base, 3);

        // OP_COUNT held through the busy and done cycles is ignored
        base = wr_total;
        reg_write(4'h9, 16'h0700); reg_write(4'hA, 16'hC0DE); reg_write(4'hB, 16'd1);
        exp_q.push_back({16'h0700, 16'hC0DE});
        @(negedge clk); reg_wr_i = 1'b1; reg_num_i = 4'h7; reg_data_i = 16'd1;
        @(negedge clk); reg_data_i = 16'd2;
        @(negedge clk);
        chk("donecyc_done", {31'd0, done_o}, 1);
        @(negedge clk); reg_wr_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("donecyc_count", wr_total - base, 1);
        chk("donecyc_busy", {31'd0, busy_o}, 0);

        // Reset during COPY_WAIT
        reg_write(4'hD, 16'h2000); reg_write(4'hF, 16'd1);
        reg_write(4'h9, 16'h4000); reg_write(4'hB, 16'd1);
        reg_write(4'h6, 16'h0001);
        reg_write(4'h7, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vram_sel_o && !vram_wr_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("rstcopy_rd_seen", {31'd0, found}, 1);
        reset_n_i = 1'b0;
        #1;
        chk("rstcopy_sel", {31'd0, vram_sel_o}, 0);
        chk("rstcopy_busy", {31'd0, busy_o}, 0);
        chk("rstcopy_addr_data", {vram_addr_o, vram_data_o}, 0);
        base = sel_total;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstcopy_no_strobe", sel_total - base, 0);
        chk("rstcopy_idle_busy", {31'd0, busy_o}, 0);

        // Shadows were cleared: a bare OP_COUNT fills address 0 with 0
        exp_q.push_back({16'h0000, 16'h0000});
        reg_write(4'h7, 16'd1);
        wait_done("postrst", 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blit_engine.md
BLIT_ENGINE -- requirements
Module: blit_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning VRAM word-address width.
REQ-002 SHALL have port clk, input, 1 bit: the single pixel clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port blit_cycle_i, input, 1 bit: 1 = the blitter owns VRAM this cycle (driven by the video generator).
REQ-005 SHALL have port reg_wr_i, input, 1 bit: register write strobe.
REQ-006 SHALL have port reg_num_i, input, 4 bits: register number (6=OP_MODE, 7=OP_COUNT, 9=ADDR_A, A=DATA_A, B=INCR_A, D=ADDR_B, F=INCR_B).
REQ-007 SHALL have port reg_data_i, input, 16 bits: register write data.
REQ-008 SHALL have port vram_sel_o, output, 1 bit: VRAM access strobe.
REQ-009 SHALL have port vram_wr_o, output, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port vram_addr_o, output, ADDR_W bits: VRAM word address.
REQ-011 SHALL have port vram_data_o, output, 16 bits: VRAM write data.
REQ-012 SHALL have port vram_data_i, input, 16 bits: VRAM read data, valid exactly 1 cycle after a read strobe.
REQ-013 SHALL have port busy_o, output, 1 bit: operation in progress.
REQ-014 SHALL have port done_o, output, 1 bit: 1-cycle pulse on completion.

Function
REQ-015 SHALL latch register writes for 6, 9, A, B, D and F into shadow registers at any time; all other reg_num_i values are ignored.
REQ-016 SHALL start an operation when OP_COUNT is written with a nonzero value while idle: copy the shadow registers into working registers, set count=N and set busy_o=1 in the following cycle.
REQ-017 SHALL ignore an OP_COUNT write of 0, and SHALL ignore any OP_COUNT write while busy_o=1 (including in the cycle that asserts done_o).
REQ-018 SHALL implement FSM states IDLE, FILL, COPY_RD, COPY_WAIT and COPY_WR; OP_MODE bit0 selects 0=fill (start->FILL) or 1=copy (start->COPY_RD).
REQ-019 In FILL, SHALL drive only on cycles with blit_cycle_i=1: vram_sel_o=1, vram_wr_o=1, vram_addr_o=addrA, vram_data_o=DATA_A; then addrA+=INCR_A and count-=1.
REQ-020 In COPY_RD, SHALL drive only on cycles with blit_cycle_i=1: sel=1, wr=0, addr=addrB; then addrB+=INCR_B and go to COPY_WAIT.
REQ-021 In COPY_WAIT, SHALL capture vram_data_i into a hold register unconditionally after exactly 1 cycle, then go to COPY_WR.
REQ-022 In COPY_WR, SHALL write the held word to addrA on the next cycle with blit_cycle_i=1, then addrA+=INCR_A and count-=1, returning to COPY_RD if count≠0.
REQ-023 SHALL perform all address arithmetic modulo 2^ADDR_W with INCR_A/INCR_B truncated to ADDR_W bits, so wrap past 0xFFFF continues at 0x0000.
REQ-024 When count reaches 0, SHALL return to IDLE, assert done_o for 1 cycle, and clear busy_o in the same cycle.
REQ-025 SHALL drive vram_sel_o=0 on every cycle with blit_cycle_i=0 and on every cycle not listed above.
REQ-026 SHALL register all outputs; vram_addr_o, vram_data_o and vram_wr_o hold their last values when sel=0.

Reset
REQ-027 While reset_n_i=0, SHALL force state=IDLE, busy_o=0, done_o=0, vram_sel_o=0, vram_wr_o=0, vram_addr_o=0, vram_data_o=0, all shadow/working registers=0, and count=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation immediately, with no further VRAM strobes; operation resumes only on a new OP_COUNT write after release.

Structure
REQ-029 SHALL take register-number constants and FSM state encodings from the shared Xosera definitions package, shared with the video generator.
REQ-030 SHALL be a single flat module with no sub-modules; the register decode is too small to split out.

Verification
REQ-031 Fill: ADDR_A=0x0100, INCR_A=1, DATA_A=0xABCD, mode=0, COUNT=4, blit_cycle_i always 1 -> writes of 0xABCD at 0x0100..0x0103 on 4 consecutive cycles, then done_o pulses and busy_o=0.
REQ-032 Copy: ADDR_B=0x2000, INCR_B=1, ADDR_A=0x3000, INCR_A=2, mode=1, COUNT=3, with VRAM model words 0x1111/0x2222/0x3333 -> writes 0x1111@0x3000, 0x2222@0x3002, 0x3333@0x3004.
REQ-033 Throttle: fill COUNT=2 with blit_cycle_i toggling every 2 cycles -> vram_sel_o never 1 while blit_cycle_i=0; exactly 2 writes occur.
REQ-034 Wrap: ADDR_A=0xFFFF, INCR_A=1, COUNT=2 -> writes at 0xFFFF, then 0x0000.
REQ-035 Busy and zero: a COUNT=0 write -> busy_o stays 0; OP_COUNT=5 written mid-fill -> ignored, and the original count completes.
REQ-036 Reset mid-copy: reset_n_i low during COPY_WAIT -> all outputs 0 asynchronously; after release there are no strobes until a new OP_COUNT write.
